// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, in-order credit-limited requests to a
// variable-latency imem, prefetch FIFO and the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_50,
    input  logic        rst_i,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] INST,
    output logic [31:0] PC_ID,
    output logic        inst_valid
);
    localparam int PW = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q [BUF_DEPTH];
    logic [31:0]   tag_d [BUF_DEPTH];
    logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
    logic [31:0]   buf_inst_q [BUF_DEPTH];
    logic [31:0]   buf_inst_d [BUF_DEPTH];
    logic [31:0]   buf_pc_q [BUF_DEPTH];
    logic [31:0]   buf_pc_d [BUF_DEPTH];
    logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic [CW-1:0] buf_cnt_q, buf_cnt_d, live_q, live_d, disc_q, disc_d;
    logic [31:0]   inst_q, inst_d, pc_id_q, pc_id_d;
    logic          valid_q, valid_d;

    logic [CW+1:0] used;
    logic          hs, rsp_live, rsp_drop, load, pop, bypass, push;

    always_comb begin
        used      = (CW+2)'(live_q) + (CW+2)'(disc_q) + (CW+2)'(buf_cnt_q);
        imem_req  = !rst_i && !flush && (used < (CW+2)'(BUF_DEPTH));
        imem_addr = pc_q;
        hs        = imem_req && imem_ready;
        rsp_drop  = imem_rvalid && (state_q == DRAIN);
        rsp_live  = imem_rvalid && (state_q == RUN);
        load      = !stall && !flush;
        pop       = load && (buf_cnt_q != '0);
        bypass    = load && (buf_cnt_q == '0) && rsp_live;
        push      = rsp_live && !flush && !bypass;
    end

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        tag_rd_d   = tag_rd_q;
        tag_wr_d   = tag_wr_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        buf_rd_d   = buf_rd_q;
        buf_wr_d   = buf_wr_q;
        buf_cnt_d  = buf_cnt_q;
        live_d     = live_q;
        disc_d     = disc_q;
        inst_d     = inst_q;
        pc_id_d    = pc_id_q;
        valid_d    = valid_q;

        if (hs) begin
            pc_d              = pc_q + 32'd4;
            tag_d[tag_wr_q]   = pc_q;
            tag_wr_d          = tag_wr_q + PW'(1);
        end
        if (rsp_live) tag_rd_d = tag_rd_q + PW'(1);
        live_d = live_q + CW'(hs) - CW'(rsp_live);
        disc_d = disc_q - CW'(rsp_drop);

        if (push) begin
            buf_inst_d[buf_wr_q] = imem_rdata;
            buf_pc_d[buf_wr_q]   = tag_q[tag_rd_q];
            buf_wr_d             = buf_wr_q + PW'(1);
        end
        if (pop) buf_rd_d = buf_rd_q + PW'(1);
        buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);

        if (pop) begin
            inst_d  = buf_inst_q[buf_rd_q];
            pc_id_d = buf_pc_q[buf_rd_q];
            valid_d = 1'b1;
        end else if (bypass) begin
            inst_d  = imem_rdata;
            pc_id_d = tag_q[tag_rd_q];
            valid_d = 1'b1;
        end else if (load) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end

        // Any rvalid this edge consumes one unit of either discard or live credit.
        if (flush) begin
            pc_d      = redirect_pc & ~32'h3;
            tag_rd_d  = '0;
            tag_wr_d  = '0;
            buf_rd_d  = '0;
            buf_wr_d  = '0;
            buf_cnt_d = '0;
            live_d    = '0;
            disc_d    = disc_q + live_q - CW'(imem_rvalid);
            inst_d    = NOP_INST;
            valid_d   = 1'b0;
        end

        state_d = (disc_d != '0) ? DRAIN : RUN;
    end

    always_ff @(posedge clk_50) begin
        if (rst_i) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            tag_rd_q  <= '0;
            tag_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_wr_q  <= '0;
            buf_cnt_q <= '0;
            live_q    <= '0;
            disc_q    <= '0;
            inst_q    <= NOP_INST;
            pc_id_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            tag_rd_q   <= tag_rd_d;
            tag_wr_q   <= tag_wr_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            buf_rd_q   <= buf_rd_d;
            buf_wr_q   <= buf_wr_d;
            buf_cnt_q  <= buf_cnt_d;
            live_q     <= live_d;
            disc_q     <= disc_d;
            inst_q     <= inst_d;
            pc_id_q    <= pc_id_d;
            valid_q    <= valid_d;
        end
    end

    assign INST       = inst_q;
    assign PC_ID      = pc_id_q;
    assign inst_valid = valid_q;
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Fetch end of the IF/ID interface. Produces the instruction word and PC that the decode stage consumes, and obeys the decode stage's `stall` and the pipeline's `flush`/redirect.
- Keeps a PC register and issues in-order requests to a variable-latency instruction memory using a req/ready, rvalid handshake.
- Buffers early returns in a small prefetch FIFO. Drives the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, bubble word (addi x0,x0,0) placed in IF/ID.
- BUF_DEPTH, 2, prefetch FIFO entries; also the maximum number of requests in flight. Must be 2 or 4.

Ports:
- clk_50, input, 1, system clock; all state updates on the rising edge.
- rst_i, input, 1, synchronous active-high reset.
- stall, input, 1, hazard stall from decode: hold IF/ID contents.
- flush, input, 1, redirect: kill all younger fetches and restart at redirect_pc.
- redirect_pc, input, 32, target PC; sampled only when flush=1.
- imem_req, output, 1, request valid.
- imem_addr, output, 32, request address (word aligned).
- imem_ready, input, 1, memory accepts the request this cycle.
- imem_rvalid, input, 1, response valid; responses return in order.
- imem_rdata, input, 32, response instruction word.
- INST, output, 32, IF/ID instruction.
- PC_ID, output, 32, PC of INST.
- inst_valid, output, 1, IF/ID holds a real instruction (0 = bubble).

Behaviour:
- **Reset** (rst_i=1 at an edge):
  - PC=RESET_PC. FIFO, in-flight count and discard count cleared.
  - INST=NOP_INST, PC_ID=0, inst_valid=0, imem_req=0.
  - imem_rvalid is ignored in the reset cycle. The memory shares rst_i.
- **Request issue**:
  - imem_req=1 when no flush, and (live_inflight + discard_cnt + fifo_count) < BUF_DEPTH.
  - imem_addr=PC.
  - A handshake is req&ready at an edge. It causes PC<=PC+4, pushes PC into the tag FIFO and increments live_inflight.
  - imem_req and imem_addr stay stable until accepted or flushed.
  - No credit is taken for a FIFO pop in the same cycle.
- **Response**:
  - rvalid with discard_cnt>0: drop the word and decrement discard_cnt.
  - Otherwise pair the word with the oldest tag PC and decrement live_inflight. Then:
    - If IF/ID loads this edge and the FIFO is empty, bypass the word straight into IF/ID.
    - Else push it into the FIFO.
  - Minimum latency: rvalid at edge N gives INST visible after edge N.
- **IF/ID load** (stall=0, flush=0) takes the first available of:
  - FIFO head (pop);
  - else the bypassed response;
  - else a bubble: INST=NOP_INST, inst_valid=0, PC_ID held.
- **Stall** (stall=1, flush=0):
  - INST, PC_ID and inst_valid hold.
  - Responses still fill the FIFO. Issue stops at capacity.
  - The FIFO never overflows; an rvalid while full is impossible by the credit rule.
- **Flush** has priority over stall and over a simultaneous response.
  - Same edge:
    - IF/ID becomes a bubble (NOP_INST, inst_valid=0).
    - FIFO and tag FIFO are cleared.
    - discard_cnt <= discard_cnt + live_inflight − (1 if that edge's rvalid was discarded/would count).
    - live_inflight=0.
    - PC<=redirect_pc.
  - imem_req is 0 during the flush cycle. Requests to redirect_pc start the following cycle, subject to credits.
  - Back-to-back flushes: the last one wins; discard accounting accumulates.
- **Wrap**: PC+4 wraps modulo 2^32 with no flag. Bits [1:0] of redirect_pc are forced to 0.
- **FSM**: states RUN and DRAIN.
  - DRAIN while discard_cnt>0. In DRAIN, new requests are allowed within credits and responses are dropped.
  - Return to RUN when discard_cnt reaches 0.

Test Plan:
- Reset, then imem_ready=1 with 1-cycle rvalid returning 0x00A00093 at 0x0 → first edge: imem_addr=0x0; INST=0x00A00093, PC_ID=0x0, inst_valid=1 two edges after reset release; sequential PCs 0x4, 0x8 follow.
- stall=1 for 4 cycles while memory streams → INST/PC_ID frozen; exactly BUF_DEPTH=2 requests accepted; on release, FIFO entries emerge in order (PC 0x8, 0xC) with no loss or duplicate.
- imem_ready=0 for 3 cycles → imem_req held at the same address; IF/ID shows bubbles (inst_valid=0, INST=0x00000013).
- flush with redirect_pc=0x100 while 2 requests are outstanding (latency 3) → both stale responses dropped; next inst_valid=1 has PC_ID=0x100; no stale word ever appears.
- flush and stall asserted together, with rvalid in the same cycle → bubble loaded, rvalid counted as discarded, fetch resumes at redirect_pc.
- rst_i asserted mid-stream with a full FIFO → next cycle all outputs at reset values and imem_addr=RESET_PC on the first request.
